// File: rtl/regfile_pkg.sv
// Shared defaults and data word type for the scoreboarded register file.
// The REGFILE_SB_BYPASS_EN macro (used in regfile_sb) enables same-cycle write-to-read forwarding.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits plus a registered count of pending registers.
// A reserve and a write in the same cycle on one index leave the bit set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  reserveEn,
  input  logic [ADDR_WIDTH-1:0] reserveReg,
  input  logic                  writeEn,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [ADDR_WIDTH-1:0] readRegA,
  input  logic [ADDR_WIDTH-1:0] readRegB,
  output logic                  pendingA,
  output logic                  pendingB,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pendingNext;
  logic [DEPTH-1:0]  setMask;
  logic [DEPTH-1:0]  clrMask;
  logic [ADDR_WIDTH:0] countNext;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (reserveEn) setMask[reserveReg] = 1'b1;
    if (writeEn)   clrMask[writeReg]   = 1'b1;
    if (ZERO_REG != 0) setMask[0] = 1'b0;
    pendingNext = (pending & ~clrMask) | setMask;
    countNext = '0;
    for (int i = 0; i < DEPTH; i++) begin
      countNext = countNext + {{ADDR_WIDTH{1'b0}}, pendingNext[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      pending      <= '0;
      pendingCount <= '0;
    end else begin
      pending      <= pendingNext;
      pendingCount <= countNext;
    end
  end

  assign pendingA = pending[readRegA];
  assign pendingB = pending[readRegB];

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with a reservation scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward write data to matching reads in the same cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEn,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_reserveEn,
  input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic pendingA, pendingB;
  logic zeroA, zeroB;
  logic writeHitA, writeHitB;
  logic writeAllowed;

  assign writeAllowed = ctrl_writeEn && !((ZERO_REG != 0) && (ctrl_writeReg == '0));

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (writeAllowed) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) scoreboard (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .reserveEn   (ctrl_reserveEn),
    .reserveReg  (ctrl_reserveReg),
    .writeEn     (ctrl_writeEn),
    .writeReg    (ctrl_writeReg),
    .readRegA    (ctrl_readRegA),
    .readRegB    (ctrl_readRegB),
    .pendingA    (pendingA),
    .pendingB    (pendingB),
    .pendingCount(pending_count)
  );

  assign zeroA = (ZERO_REG != 0) && (ctrl_readRegA == '0);
  assign zeroB = (ZERO_REG != 0) && (ctrl_readRegB == '0);

`ifdef REGFILE_SB_BYPASS_EN
  // Forwarding is held off during reset because that write never lands.
  assign writeHitA = ctrl_writeEn && !ctrl_reset && !zeroA && (ctrl_writeReg == ctrl_readRegA);
  assign writeHitB = ctrl_writeEn && !ctrl_reset && !zeroB && (ctrl_writeReg == ctrl_readRegB);
`else
  assign writeHitA = 1'b0;
  assign writeHitB = 1'b0;
`endif

  assign data_readRegA = zeroA ? '0 : (writeHitA ? data_writeReg : regs[ctrl_readRegA]);
  assign data_readRegB = zeroB ? '0 : (writeHitB ? data_writeReg : regs[ctrl_readRegB]);
  assign busy_readRegA = pendingA && !writeHitA;
  assign busy_readRegB = pendingB && !writeHitB;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
// Expected values for the bypass case follow whether REGFILE_SB_BYPASS_EN is defined.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  word_t       data_writeReg;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  word_t       data_readRegA, data_readRegB;
  logic        ctrl_reserveEn;
  logic [4:0]  ctrl_reserveReg;
  logic        busy_readRegA, busy_readRegB;
  logic [5:0]  pending_count;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  regfile_sb dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_writeEn   (ctrl_writeEn),
    .ctrl_writeReg  (ctrl_writeReg),
    .data_writeReg  (data_writeReg),
    .ctrl_readRegA  (ctrl_readRegA),
    .ctrl_readRegB  (ctrl_readRegB),
    .data_readRegA  (data_readRegA),
    .data_readRegB  (data_readRegB),
    .ctrl_reserveEn (ctrl_reserveEn),
    .ctrl_reserveReg(ctrl_reserveReg),
    .busy_readRegA  (busy_readRegA),
    .busy_readRegB  (busy_readRegB),
    .pending_count  (pending_count)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ctrl_writeEn   = 1'b0;
    ctrl_reserveEn = 1'b0;
    ctrl_reset     = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1; ctrl_writeEn = 1'b0; ctrl_reserveEn = 1'b0;
    ctrl_writeReg = '0; data_writeReg = '0; ctrl_reserveReg = '0;
    ctrl_readRegA = 5'd4; ctrl_readRegB = 5'd17;
    tick(); tick();
    ctrl_reset = 1'b0;
    #1;
    nCompared++;
    if (pending_count !== 6'd0) begin
      nMismatched++; $display("FAIL reset_count got %0d want 0", pending_count);
    end
    nCompared++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      nMismatched++; $display("FAIL reset_data got %h/%h want 0/0", data_readRegA, data_readRegB);
    end
    nCompared++;
    if (busy_readRegA !== 1'b0 || busy_readRegB !== 1'b0) begin
      nMismatched++; $display("FAIL reset_busy got %b/%b want 0/0", busy_readRegA, busy_readRegB);
    end
  endtask

  task automatic test_write_read();
    word_t expA, expB;
    int kb;
    for (int k = 0; k < 32; k++) begin
      ctrl_writeEn = 1'b1; ctrl_writeReg = 5'(k); data_writeReg = 32'h1 << k;
      tick();
    end
    idle();
    for (int k = 0; k < 32; k++) begin
      kb = 31 - k;
      ctrl_readRegA = 5'(k); ctrl_readRegB = 5'(kb);
      #1;
      expA = (k == 0) ? 32'h0 : (32'h1 << k);
      expB = (kb == 0) ? 32'h0 : (32'h1 << kb);
      nCompared++;
      if (data_readRegA !== expA || data_readRegB !== expB) begin
        nMismatched++;
        $display("FAIL read_r%0d_r%0d got %h/%h want %h/%h", k, kb, data_readRegA, data_readRegB, expA, expB);
      end
    end
    nCompared++;
    if (pending_count !== 6'd0) begin
      nMismatched++; $display("FAIL write_count got %0d want 0", pending_count);
    end
  endtask

  task automatic test_reserve();
    ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'd5;
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd6;
    tick();
    idle();
    #1;
    nCompared++;
    if (busy_readRegA !== 1'b1 || busy_readRegB !== 1'b0 || pending_count !== 6'd1) begin
      nMismatched++;
      $display("FAIL reserve_r5 got busy %b/%b cnt %0d want 1/0 cnt 1", busy_readRegA, busy_readRegB, pending_count);
    end
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEAD;
    tick();
    idle();
    #1;
    nCompared++;
    if (busy_readRegA !== 1'b0 || data_readRegA !== 32'hDEAD || pending_count !== 6'd0) begin
      nMismatched++;
      $display("FAIL retire_r5 got busy %b data %h cnt %0d want 0 0000dead 0", busy_readRegA, data_readRegA, pending_count);
    end
  endtask

  task automatic test_same_cycle();
    ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'd7;
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h1234;
    ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd7;
    tick();
    idle();
    #1;
    nCompared++;
    if (data_readRegA !== 32'h1234 || busy_readRegA !== 1'b1 || pending_count !== 6'd1) begin
      nMismatched++;
      $display("FAIL same_r7 got data %h busy %b cnt %0d want 00001234 1 1", data_readRegA, busy_readRegA, pending_count);
    end
    nCompared++;
    if (data_readRegB !== 32'h1234 || busy_readRegB !== 1'b1) begin
      nMismatched++; $display("FAIL same_r7_portB got %h busy %b want 00001234 1", data_readRegB, busy_readRegB);
    end
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h5678;
    tick();
    idle();
    #1;
    nCompared++;
    if (pending_count !== 6'd0 || busy_readRegA !== 1'b0) begin
      nMismatched++; $display("FAIL clear_r7 got cnt %0d busy %b want 0 0", pending_count, busy_readRegA);
    end
  endtask

  task automatic test_bypass();
    word_t expData;
    logic  expBusy;
    ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'd3;
    tick();
    idle();
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd3;
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'hBEEF;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    expData = 32'hBEEF; expBusy = 1'b0;
`else
    expData = 32'h8; expBusy = 1'b1;
`endif
    nCompared++;
    if (data_readRegA !== expData || busy_readRegA !== expBusy) begin
      nMismatched++;
      $display("FAIL bypass_same got %h busy %b want %h busy %b", data_readRegA, busy_readRegA, expData, expBusy);
    end
    nCompared++;
    if (data_readRegB !== data_readRegA || busy_readRegB !== busy_readRegA) begin
      nMismatched++; $display("FAIL bypass_portB got %h busy %b want %h busy %b", data_readRegB, busy_readRegB, expData, expBusy);
    end
    tick();
    idle();
    #1;
    nCompared++;
    if (data_readRegA !== 32'hBEEF || busy_readRegA !== 1'b0 || pending_count !== 6'd0) begin
      nMismatched++;
      $display("FAIL bypass_next got %h busy %b cnt %0d want 0000beef 0 0", data_readRegA, busy_readRegA, pending_count);
    end
    // Reset with a write to the read index: no forwarding, and the write is dropped.
    ctrl_reset = 1'b1; ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'hCAFE;
    #1;
    nCompared++;
    if (data_readRegA !== 32'hBEEF) begin
      nMismatched++; $display("FAIL bypass_in_reset got %h want 0000beef", data_readRegA);
    end
    tick();
    idle();
    #1;
    nCompared++;
    if (data_readRegA !== 32'h0) begin
      nMismatched++; $display("FAIL reset_drops_write got %h want 0", data_readRegA);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k < 32; k++) begin
      ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'(k);
      tick();
    end
    idle();
    ctrl_readRegA = 5'd1; ctrl_readRegB = 5'd31;
    #1;
    nCompared++;
    if (pending_count !== 6'd31 || busy_readRegA !== 1'b1 || busy_readRegB !== 1'b1) begin
      nMismatched++;
      $display("FAIL all_reserved got cnt %0d busy %b/%b want 31 1/1", pending_count, busy_readRegA, busy_readRegB);
    end
    ctrl_reset = 1'b1; ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'd2;
    tick();
    idle();
    ctrl_readRegB = 5'd2;
    #1;
    nCompared++;
    if (pending_count !== 6'd0 || busy_readRegA !== 1'b0 || busy_readRegB !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_clears_pending got cnt %0d busy %b/%b want 0 0/0", pending_count, busy_readRegA, busy_readRegB);
    end
    ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'd0;
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hFFFF_FFFF;
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    tick();
    idle();
    #1;
    nCompared++;
    if (pending_count !== 6'd0 || busy_readRegA !== 1'b0 || data_readRegA !== 32'h0) begin
      nMismatched++;
      $display("FAIL zero_reg got cnt %0d busy %b data %h want 0 0 0", pending_count, busy_readRegA, data_readRegA);
    end
  endtask

  task automatic test_double_reserve();
    ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd10;
    ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'd9;
    tick();
    #1;
    nCompared++;
    if (pending_count !== 6'd1) begin
      nMismatched++; $display("FAIL reserve_r9_first got %0d want 1", pending_count);
    end
    tick();
    idle();
    #1;
    nCompared++;
    if (pending_count !== 6'd1 || busy_readRegA !== 1'b1) begin
      nMismatched++; $display("FAIL reserve_r9_again got cnt %0d busy %b want 1 1", pending_count, busy_readRegA);
    end
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h99;
    tick();
    idle();
    #1;
    nCompared++;
    if (pending_count !== 6'd0 || busy_readRegA !== 1'b0 || data_readRegA !== 32'h99) begin
      nMismatched++;
      $display("FAIL retire_r9 got cnt %0d busy %b data %h want 0 0 00000099", pending_count, busy_readRegA, data_readRegA);
    end
    // Reserve r10 while retiring pending r11: count stays at 1.
    ctrl_reserveEn = 1'b1; ctrl_reserveReg = 5'd11;
    tick();
    ctrl_reserveReg = 5'd10;
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd11; data_writeReg = 32'hB0B;
    ctrl_readRegA = 5'd11;
    tick();
    idle();
    #1;
    nCompared++;
    if (pending_count !== 6'd1 || busy_readRegA !== 1'b0 || busy_readRegB !== 1'b1) begin
      nMismatched++;
      $display("FAIL swap_r10_r11 got cnt %0d busy11 %b busy10 %b want 1 0 1", pending_count, busy_readRegA, busy_readRegB);
    end
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd12; data_writeReg = 32'h12;
    tick();
    idle();
    #1;
    nCompared++;
    if (pending_count !== 6'd1) begin
      nMismatched++; $display("FAIL write_nonpending got cnt %0d want 1", pending_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reserve();
    test_same_cycle();
    test_bypass();
    test_reset_mid();
    test_double_reserve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and data-port width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads 0 and ignores writes and reservations.
REQ-004 Design has one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 ctrl_reset  in  1  synchronous active-high reset.
REQ-007 ctrl_writeEn  in  1  write strobe.
REQ-008 ctrl_writeReg  in  ADDR_WIDTH  write index.
REQ-009 data_writeReg  in  DATA_WIDTH  write data.
REQ-010 ctrl_readRegA / ctrl_readRegB  in  ADDR_WIDTH each  read indices, ports A and B.
REQ-011 data_readRegA / data_readRegB  out  DATA_WIDTH each  read data.
REQ-012 ctrl_reserveEn  in  1  mark a register as awaiting a pending producer.
REQ-013 ctrl_reserveReg  in  ADDR_WIDTH  index to reserve.
REQ-014 busy_readRegA / busy_readRegB  out  1 each  addressed register is pending.
REQ-015 pending_count  out  ADDR_WIDTH+1  number of pending registers.

Function
REQ-016 Reads are combinational: data_readRegX = reg[ctrl_readRegX] in the same cycle; zero latency.
REQ-017 Write with ctrl_writeEn=1 updates reg[ctrl_writeReg] at the rising edge; visible on reads from the following cycle.
REQ-018 ZERO_REG=1: index 0 always reads 0, busy 0; writes and reservations to 0 have no effect.
REQ-019 Per-register pending bit: reserve sets it at the edge; write to the same index clears it at the edge.
REQ-020 Same-cycle reserve and write to the same index: pending ends set (new producer wins); data is still written.
REQ-021 Reserve of an already-pending index: no change; pending_count not incremented.
REQ-022 Write to a non-pending index: data written, pending_count unchanged, no error.
REQ-023 pending_count is registered and always equals popcount of pending bits; range 0..DEPTH (DEPTH-1 with ZERO_REG=1), never wraps.
REQ-024 Reserve of X and write of pending Y in the same cycle, X!=Y, X not pending: pending_count unchanged.
REQ-025 Ports A and B are independent; same index on both ports returns identical data and busy.

Reset
REQ-026 ctrl_reset=1 at a rising edge clears every register to 0, every pending bit to 0 and pending_count to 0.
REQ-027 Reset overrides a simultaneous write or reserve; neither takes effect.
REQ-028 After reset, reads return 0 and busy outputs are 0 from the next cycle.

Configuration
REQ-029 Macro REGFILE_SB_BYPASS_EN defined: when ctrl_writeEn=1 and ctrl_writeReg equals a read index (not zero-reg), that port returns data_writeReg and busy 0 in the same cycle.
REQ-030 Macro undefined: no bypass; read returns old value and busy stays 1 until after the edge.
REQ-031 Bypass is suppressed while ctrl_reset=1.

Structure
REQ-032 Shared package regfile_pkg holds default DATA_WIDTH/ADDR_WIDTH constants and a data word typedef.
REQ-033 Pending bits and pending_count live in sub-module regfile_scoreboard; regfile_sb instantiates it once.

Verification
REQ-034 Reset 2 cycles; write reg k with 1<<k for k=0..31; read all on A and B -> reg0=0, reg k=1<<k, pending_count=0.
REQ-035 Reserve r5 -> next cycle busy_readRegA=1 at index 5, pending_count=1; write r5=0xDEAD -> next cycle busy 0, data 0xDEAD, count 0.
REQ-036 Same cycle reserve r7 and write r7=0x1234 -> next cycle data 0x1234, busy 1, count 1.
REQ-037 With REGFILE_SB_BYPASS_EN: write r3=0xBEEF while reading r3 -> same-cycle data 0xBEEF; without macro -> old value, 0xBEEF next cycle.
REQ-038 Reserve r1..r31, then reset mid-sequence -> count 31 before, all busy 0 and count 0 after the reset edge; reserve r0 -> count stays 0.
REQ-039 Reserve r9 twice, write r9 once -> count 1 then 0, never 2.
